// File: rtl/watch_mode_controller_pkg.sv
// Shared types, BCD limits and the two-digit BCD increment used by the
// watch mode controller.
package watch_ctrl_pkg;

   typedef enum logic [1:0] {
      STOP = 2'd0,
      RUN  = 2'd1,
      SET  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      HR  = 2'd0,
      MIN = 2'd1,
      SEC = 2'd2
   } field_t;

   localparam logic [7:0] HR_MAX = 8'h23;
   localparam logic [7:0] MS_MAX = 8'h59;

   // Anything at or past the limit wraps to 00, so a stray out-of-range
   // captured value still recovers on the next increment.
   function automatic logic [7:0] bcd2_inc(input logic [7:0] value, input logic [7:0] max);
      logic [7:0] result;
      if (value >= max) begin
         result = 8'h00;
      end else if (value[3:0] == 4'd9) begin
         result = {value[7:4] + 4'd1, 4'h0};
      end else begin
         result = value + 8'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/watch_mode_controller_if.sv
// Button, live-time and chain-control signals of the watch mode controller.
// Levels: buttons are debounced levels; count_en, clear and load are
// one-cycle pulses, never more than one of them high in a cycle.
interface watch_mode_controller_if;
   import watch_ctrl_pkg::*;

   logic       btn_startstop;
   logic       btn_clear;
   logic       btn_mode;
   logic       btn_sel;
   logic       btn_inc;
   logic [3:0] cur_hr1, cur_hr0, cur_min1, cur_min0, cur_sec1, cur_sec0;
   logic       count_en;
   logic       clear;
   logic       load;
   logic [3:0] ld_hr1, ld_hr0, ld_min1, ld_min0, ld_sec1, ld_sec0;
   logic       running;
   logic       set_mode;
   logic [1:0] edit_field;
   state_t     state;

   modport master (
      output btn_startstop, btn_clear, btn_mode, btn_sel, btn_inc,
      output cur_hr1, cur_hr0, cur_min1, cur_min0, cur_sec1, cur_sec0,
      input  count_en, clear, load,
      input  ld_hr1, ld_hr0, ld_min1, ld_min0, ld_sec1, ld_sec0,
      input  running, set_mode, edit_field, state
   );

   modport slave (
      input  btn_startstop, btn_clear, btn_mode, btn_sel, btn_inc,
      input  cur_hr1, cur_hr0, cur_min1, cur_min0, cur_sec1, cur_sec0,
      output count_en, clear, load,
      output ld_hr1, ld_hr0, ld_min1, ld_min0, ld_sec1, ld_sec0,
      output running, set_mode, edit_field, state
   );

endinterface

// File: rtl/watch_mode_controller_btn_event.sv
// Rising-edge detector for one debounced button level.
module btn_event (
   input  logic clk,
   input  logic btn,
   output logic pulse
);

   logic prev;

   // prev follows the button in reset too, so a button held through reset
   // does not fire when reset drops.
   always_ff @(posedge clk) begin
      prev <= btn;
   end

   assign pulse = btn & ~prev;

endmodule

// File: rtl/watch_mode_controller.sv
// STOP/RUN/SET sequencer for the BCD hh:mm:ss chain: 1 Hz tick prescaler,
// button events, and a private edit copy committed with a single load pulse.
module watch_mode_controller
   import watch_ctrl_pkg::*;
#(
   parameter int TICK_DIV = 100
) (
   input logic clk,
   input logic reset,
   watch_mode_controller_if.slave ctrl
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic ev_ss, ev_clr, ev_mode, ev_sel, ev_inc;

   btn_event u_ss   (.clk(clk), .btn(ctrl.btn_startstop), .pulse(ev_ss));
   btn_event u_clr  (.clk(clk), .btn(ctrl.btn_clear),     .pulse(ev_clr));
   btn_event u_mode (.clk(clk), .btn(ctrl.btn_mode),      .pulse(ev_mode));
   btn_event u_sel  (.clk(clk), .btn(ctrl.btn_sel),       .pulse(ev_sel));
   btn_event u_inc  (.clk(clk), .btn(ctrl.btn_inc),       .pulse(ev_inc));

   state_t          state, state_n;
   field_t          field, field_n;
   logic [PW-1:0]   presc, presc_n;
   logic [7:0]      ed_hr, ed_min, ed_sec, ed_hr_n, ed_min_n, ed_sec_n;
   logic            count_en_q, clear_q, load_q, running_q, set_mode_q;
   logic            count_en_n, clear_n, load_n;

   always_comb begin
      state_n    = state;
      field_n    = field;
      presc_n    = '0;
      ed_hr_n    = ed_hr;
      ed_min_n   = ed_min;
      ed_sec_n   = ed_sec;
      count_en_n = 1'b0;
      clear_n    = 1'b0;
      load_n     = 1'b0;
      case (state)
         STOP: begin
            if (ev_mode) begin
               state_n  = SET;
               field_n  = HR;
               ed_hr_n  = {ctrl.cur_hr1, ctrl.cur_hr0};
               ed_min_n = {ctrl.cur_min1, ctrl.cur_min0};
               ed_sec_n = {ctrl.cur_sec1, ctrl.cur_sec0};
            end else if (ev_ss) begin
               state_n = RUN;
            end else if (ev_clr) begin
               clear_n = 1'b1;
            end
         end
         RUN: begin
            // Entering SET drops any tick due this cycle; stopping does not.
            if (ev_mode) begin
               state_n  = SET;
               field_n  = HR;
               ed_hr_n  = {ctrl.cur_hr1, ctrl.cur_hr0};
               ed_min_n = {ctrl.cur_min1, ctrl.cur_min0};
               ed_sec_n = {ctrl.cur_sec1, ctrl.cur_sec0};
            end else begin
               if (presc == LAST) begin
                  count_en_n = 1'b1;
               end else begin
                  presc_n = presc + 1'b1;
               end
               if (ev_ss) begin
                  state_n = STOP;
                  presc_n = '0;
               end
            end
         end
         SET: begin
            if (ev_mode) begin
               load_n  = 1'b1;
               state_n = STOP;
            end else if (ev_sel) begin
               case (field)
                  HR:      field_n = MIN;
                  MIN:     field_n = SEC;
                  default: field_n = HR;
               endcase
            end else if (ev_inc) begin
               case (field)
                  HR:      ed_hr_n  = bcd2_inc(ed_hr, HR_MAX);
                  MIN:     ed_min_n = bcd2_inc(ed_min, MS_MAX);
                  default: ed_sec_n = bcd2_inc(ed_sec, MS_MAX);
               endcase
            end
         end
         default: state_n = STOP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= STOP;
         field      <= HR;
         presc      <= '0;
         ed_hr      <= 8'h00;
         ed_min     <= 8'h00;
         ed_sec     <= 8'h00;
         count_en_q <= 1'b0;
         clear_q    <= 1'b0;
         load_q     <= 1'b0;
         running_q  <= 1'b0;
         set_mode_q <= 1'b0;
      end else begin
         state      <= state_n;
         field      <= field_n;
         presc      <= presc_n;
         ed_hr      <= ed_hr_n;
         ed_min     <= ed_min_n;
         ed_sec     <= ed_sec_n;
         count_en_q <= count_en_n;
         clear_q    <= clear_n;
         load_q     <= load_n;
         running_q  <= (state_n == RUN);
         set_mode_q <= (state_n == SET);
      end
   end

   assign ctrl.count_en   = count_en_q;
   assign ctrl.clear      = clear_q;
   assign ctrl.load       = load_q;
   assign ctrl.running    = running_q;
   assign ctrl.set_mode   = set_mode_q;
   assign ctrl.edit_field = field;
   assign ctrl.state      = state;
   assign {ctrl.ld_hr1, ctrl.ld_hr0}   = ed_hr;
   assign {ctrl.ld_min1, ctrl.ld_min0} = ed_min;
   assign {ctrl.ld_sec1, ctrl.ld_sec0} = ed_sec;

endmodule

// File: tb/tb_watch_mode_controller.sv
// Bench for watch_mode_controller: scripted vector table, corner-case
// sequences, then random buttons against an integer-time reference model.
module tb_watch_mode_controller;

   localparam int TD   = 4;
   localparam int SS   = 0;
   localparam int CLR  = 1;
   localparam int MODE = 2;
   localparam int SEL  = 3;
   localparam int INC  = 4;

   logic        clk;
   logic        reset;
   logic [4:0]  b;
   logic [23:0] cur;
   int          checks;
   int          errors;

   watch_mode_controller_if wif ();

   watch_mode_controller #(.TICK_DIV(TD)) dut (
      .clk   (clk),
      .reset (reset),
      .ctrl  (wif)
   );

   assign wif.btn_startstop = b[SS];
   assign wif.btn_clear     = b[CLR];
   assign wif.btn_mode      = b[MODE];
   assign wif.btn_sel       = b[SEL];
   assign wif.btn_inc       = b[INC];
   assign {wif.cur_hr1, wif.cur_hr0, wif.cur_min1, wif.cur_min0, wif.cur_sec1, wif.cur_sec0} = cur;

   logic [23:0] ld_act;
   assign ld_act = {wif.ld_hr1, wif.ld_hr0, wif.ld_min1, wif.ld_min0, wif.ld_sec1, wif.ld_sec0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic run, input logic setm, input logic [1:0] fld,
                          input logic cl, input logic ldp, input logic cen, input logic [23:0] ldv);
      chk({tag, ".running"},    32'(wif.running),    32'(run));
      chk({tag, ".set_mode"},   32'(wif.set_mode),   32'(setm));
      chk({tag, ".edit_field"}, 32'(wif.edit_field), 32'(fld));
      chk({tag, ".clear"},      32'(wif.clear),      32'(cl));
      chk({tag, ".load"},       32'(wif.load),       32'(ldp));
      chk({tag, ".count_en"},   32'(wif.count_en),   32'(cen));
      chk({tag, ".ld"},         32'(ld_act),         32'(ldv));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic tap(input int idx);
      b[idx] = 1'b1;
      step();
      b[idx] = 1'b0;
      step();
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   typedef struct {
      logic ss, clr, mode, sel, inc;
      logic run, setm;
      logic [1:0] fld;
      logic cl, ldp, cen;
      logic [23:0] ldv;
   } vec_t;

   vec_t vecs[19];

   // Reference model: time as plain integers, ticks from cycles since RUN entry.
   int          m_st, m_h, m_m, m_s, m_f, m_cyc, m_start;
   int          c_h, c_m, c_s;
   logic [4:0]  m_prev;
   logic        e_cl, e_ld, e_cen;

   task automatic model_reset();
      m_st = 0; m_h = 0; m_m = 0; m_s = 0; m_f = 0;
      m_prev = b;
      e_cl = 1'b0; e_ld = 1'b0; e_cen = 1'b0;
   endtask

   task automatic model_capture();
      m_h = c_h; m_m = c_m; m_s = c_s; m_f = 0; m_st = 2;
   endtask

   task automatic model_step();
      logic [4:0] ev;
      ev = b & ~m_prev;
      m_prev = b;
      m_cyc++;
      e_cl = 1'b0; e_ld = 1'b0; e_cen = 1'b0;
      case (m_st)
         0: begin
            if (ev[MODE]) model_capture();
            else if (ev[SS]) begin m_st = 1; m_start = m_cyc; end
            else if (ev[CLR]) e_cl = 1'b1;
         end
         1: begin
            if (ev[MODE]) model_capture();
            else begin
               if ((m_cyc - m_start) % TD == 0) e_cen = 1'b1;
               if (ev[SS]) m_st = 0;
            end
         end
         default: begin
            if (ev[MODE]) begin e_ld = 1'b1; m_st = 0; end
            else if (ev[SEL]) m_f = (m_f + 1) % 3;
            else if (ev[INC]) begin
               if (m_f == 0) m_h = (m_h + 1) % 24;
               else if (m_f == 1) m_m = (m_m + 1) % 60;
               else m_s = (m_s + 1) % 60;
            end
         end
      endcase
   endtask

   initial begin
      checks = 0;
      errors = 0;
      b = '0;
      cur = 24'h123456;
      reset = 1'b0;

      // Reset state
      do_reset();
      chk_all("reset", 0, 0, 2'd0, 0, 0, 0, 24'h000000);

      // ss clr mode sel inc | run set fld clr load cen | ld
      vecs[0]  = '{0,0,0,0,0, 0,0,2'd0, 0,0,0, 24'h000000};
      vecs[1]  = '{0,1,0,0,0, 0,0,2'd0, 1,0,0, 24'h000000};
      vecs[2]  = '{0,1,0,0,0, 0,0,2'd0, 0,0,0, 24'h000000};
      vecs[3]  = '{0,0,0,0,0, 0,0,2'd0, 0,0,0, 24'h000000};
      vecs[4]  = '{1,0,0,0,0, 1,0,2'd0, 0,0,0, 24'h000000};
      vecs[5]  = '{0,0,0,0,0, 1,0,2'd0, 0,0,0, 24'h000000};
      vecs[6]  = '{0,0,0,0,0, 1,0,2'd0, 0,0,0, 24'h000000};
      vecs[7]  = '{0,1,0,0,0, 1,0,2'd0, 0,0,0, 24'h000000};
      vecs[8]  = '{0,0,0,0,0, 1,0,2'd0, 0,0,1, 24'h000000};
      vecs[9]  = '{0,0,0,0,0, 1,0,2'd0, 0,0,0, 24'h000000};
      vecs[10] = '{0,0,1,0,0, 0,1,2'd0, 0,0,0, 24'h123456};
      vecs[11] = '{0,0,0,1,0, 0,1,2'd1, 0,0,0, 24'h123456};
      vecs[12] = '{0,0,0,0,0, 0,1,2'd1, 0,0,0, 24'h123456};
      vecs[13] = '{0,0,0,1,1, 0,1,2'd2, 0,0,0, 24'h123456};
      vecs[14] = '{0,0,0,0,0, 0,1,2'd2, 0,0,0, 24'h123456};
      vecs[15] = '{0,0,0,0,1, 0,1,2'd2, 0,0,0, 24'h123457};
      vecs[16] = '{1,0,0,0,0, 0,1,2'd2, 0,0,0, 24'h123457};
      vecs[17] = '{0,0,1,0,0, 0,0,2'd2, 0,1,0, 24'h123457};
      vecs[18] = '{0,0,0,0,0, 0,0,2'd2, 0,0,0, 24'h123457};

      for (int i = 0; i < 19; i++) begin
         b = {vecs[i].inc, vecs[i].sel, vecs[i].mode, vecs[i].clr, vecs[i].ss};
         step();
         chk_all($sformatf("vec%0d", i), vecs[i].run, vecs[i].setm, vecs[i].fld,
                 vecs[i].cl, vecs[i].ldp, vecs[i].cen, vecs[i].ldv);
      end
      b = '0;
      step();

      // 13 increments of hours: 12 -> 23 -> 00 -> 01, then commit
      do_reset();
      cur = 24'h123456;
      tap(MODE);
      chk("hr.set_mode", 32'(wif.set_mode), 32'd1);
      chk("hr.field", 32'(wif.edit_field), 32'd0);
      for (int i = 0; i < 13; i++) tap(INC);
      chk("hr.ld", 32'(ld_act), 32'h013456);
      b[MODE] = 1'b1;
      step();
      chk("hr.load", 32'(wif.load), 32'd1);
      chk("hr.ld_at_load", 32'(ld_act), 32'h013456);
      chk("hr.set_off", 32'(wif.set_mode), 32'd0);
      b[MODE] = 1'b0;
      step();
      chk("hr.load_one_cycle", 32'(wif.load), 32'd0);
      chk("hr.stop", 32'(wif.running), 32'd0);

      // Seconds 59 -> 00 without carry into minutes
      do_reset();
      cur = 24'h123459;
      tap(MODE);
      tap(SEL);
      tap(SEL);
      chk("sec.field", 32'(wif.edit_field), 32'd2);
      tap(INC);
      chk("sec.wrap", 32'(ld_act), 32'h123400);
      tap(SEL);
      chk("sec.field_wrap", 32'(wif.edit_field), 32'd0);

      // Coincident events: mode beats startstop; sel beats inc
      do_reset();
      b[MODE] = 1'b1;
      b[SS] = 1'b1;
      step();
      chk("prio.set", 32'(wif.set_mode), 32'd1);
      chk("prio.norun", 32'(wif.running), 32'd0);
      b = '0;
      step();
      b[SEL] = 1'b1;
      b[INC] = 1'b1;
      step();
      chk("prio.field", 32'(wif.edit_field), 32'd1);
      chk("prio.value", 32'(ld_act), 32'h123459);
      b = '0;
      step();

      // Button held through reset release gives no event
      reset = 1'b1;
      b[SS] = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
      step();
      chk("held.norun", 32'(wif.running), 32'd0);
      b[SS] = 1'b0;
      step();
      b[SS] = 1'b1;
      step();
      chk("held.fresh_press", 32'(wif.running), 32'd1);
      b[SS] = 1'b0;
      step();

      // Reset mid-SET discards edits and issues no load
      do_reset();
      tap(MODE);
      tap(INC);
      chk("rstset.edited", 32'(ld_act), 32'h133459);
      reset = 1'b1;
      b[MODE] = 1'b1;
      step();
      chk("rstset.load", 32'(wif.load), 32'd0);
      chk("rstset.set", 32'(wif.set_mode), 32'd0);
      chk("rstset.ld", 32'(ld_act), 32'h000000);
      reset = 1'b0;
      step();
      chk("rstset.load_after", 32'(wif.load), 32'd0);
      chk("rstset.stop", 32'(wif.set_mode), 32'd0);
      b = '0;
      step();

      // Random buttons against the reference model
      m_cyc = 0;
      m_start = 0;
      for (int i = 0; i < 1500; i++) begin
         logic rst;
         rst = (i == 0) || ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 11) == 0) b[SS]   = ~b[SS];
         if ($urandom_range(0, 3)  == 0) b[CLR]  = ~b[CLR];
         if ($urandom_range(0, 15) == 0) b[MODE] = ~b[MODE];
         if ($urandom_range(0, 3)  == 0) b[SEL]  = ~b[SEL];
         if ($urandom_range(0, 2)  == 0) b[INC]  = ~b[INC];
         c_h = int'($urandom_range(0, 23));
         c_m = int'($urandom_range(0, 59));
         c_s = int'($urandom_range(0, 59));
         cur = {to_bcd(c_h), to_bcd(c_m), to_bcd(c_s)};
         reset = rst;
         step();
         if (rst) model_reset();
         else model_step();
         chk_all("rand", m_st == 1, m_st == 2, 2'(m_f), e_cl, e_ld, e_cen,
                 {to_bcd(m_h), to_bcd(m_m), to_bcd(m_s)});
         chk("rand.exclusive", 32'(int'(wif.count_en) + int'(wif.clear) + int'(wif.load) <= 1), 32'd1);
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/watch_mode_controller.md
Name: watch_mode_controller

Overview:
Control FSM that sequences the BCD hh:mm:ss counter chain.
- Generates the 1 Hz count tick from the system clock.
- Turns the start/stop, clear, mode, select and increment buttons into one-cycle events.
- Runs a set-time mode that edits a private copy of the time and commits it to the chain with a single load pulse.
- Sits between the debounced button inputs and the watch counter chain.

Parameters:
TICK_DIV, 100, clk cycles per count tick (minimum 2)

Ports:
clk  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
btn_startstop  input  1  synchronized, debounced level
btn_clear  input  1  synchronized, debounced level
btn_mode  input  1  synchronized, debounced level
btn_sel  input  1  synchronized, debounced level
btn_inc  input  1  synchronized, debounced level
cur_hr1, cur_hr0, cur_min1, cur_min0, cur_sec1, cur_sec0  input  4 each  live BCD time from the counter chain
count_en  output  1  one-cycle count pulse to the chain
clear  output  1  one-cycle pulse; zeroes the chain
load  output  1  one-cycle pulse; chain loads ld_* values
ld_hr1, ld_hr0, ld_min1, ld_min0, ld_sec1, ld_sec0  output  4 each  edited BCD time
running  output  1  high in RUN
set_mode  output  1  high in SET
edit_field  output  2  0=HR, 1=MIN, 2=SEC; value 3 is never produced

Behaviour:
- Reset: state=STOP, prescaler=0, edit registers=00:00:00, edit_field=HR; all pulse outputs 0; running=0, set_mode=0.
- During reset, each button's previous-value register loads the current input, so a button held through reset produces no event.
- Event definition: btn=1 and prev=0 in the same cycle; prev<=btn every cycle.
- All outputs are registered; the response appears the cycle after the event.
- Prescaler: counts 0..TICK_DIV-1 only in RUN; held at 0 in STOP and SET.
  - count_en=1 for exactly one cycle when prescaler wraps TICK_DIV-1 -> 0.
  - First count_en occurs TICK_DIV cycles after entering RUN.
- Edge priority when several events coincide:
  - STOP/RUN: mode > startstop > clear.
  - SET: mode > sel > inc.
  - Lower-priority events in the same cycle are dropped.
- STOP state:
  - startstop -> RUN.
  - clear -> clear pulse, stay in STOP.
  - mode -> SET: capture cur_* into edit registers; edit_field=HR.
- RUN state:
  - startstop -> STOP; prescaler zeroed.
  - mode -> SET, with the same capture as from STOP; a tick due in that cycle is suppressed.
  - clear is ignored.
- SET state:
  - sel: edit_field HR->MIN->SEC->HR.
  - inc: selected field +1 in BCD with wrap. HR 23->00, 09->10, 19->20. MIN/SEC 59->00, x9->(x+1)0.
  - startstop and clear are ignored.
  - mode: load=1 for one cycle with ld_*=edit values, then -> STOP.
- ld_* always reflect the edit registers; they are only meaningful while load=1.
- count_en, clear and load are mutually exclusive in every cycle.
- Reset mid-SET discards edits; no load is issued.

Decomposition:
- Package watch_ctrl_pkg:
  - state enum STOP/RUN/SET.
  - field enum HR/MIN/SEC.
  - BCD limits HR_MAX=8'h23, MS_MAX=8'h59.
  - function bcd2_inc(value, max) returning the wrapped two-digit BCD increment.
- Sub-module btn_event: one instance per button; holds the prev register and emits the one-cycle event.
- FSM, prescaler and edit registers stay in the top module.

Test Plan:
1. Reset, then startstop pulse with TICK_DIV=4 -> running=1; count_en pulses every 4 cycles, first one 4 cycles after RUN entry.
2. RUN, startstop pulse -> count_en stops; running=0. Clear pulse in STOP -> clear high exactly 1 cycle. Clear pulse in RUN -> no clear.
3. cur=12:34:56 in STOP; mode -> set_mode=1, edit_field=0. 13 inc events -> hr=01 (12->23->00->01). Mode -> load 1 cycle with ld=01:34:56; state STOP.
4. SET: sel twice to SEC, cur sec=59; inc -> sec=00 with no carry to min. sel -> edit_field=HR.
5. mode and startstop rising in the same cycle in STOP -> SET entered; no RUN. In SET, sel+inc together -> field advances; value unchanged.
6. Button held high through reset release -> no event. Reset asserted mid-SET -> load stays 0, state STOP, edit registers 00:00:00.
